// File: rtl/vectorial_alu_pipe.sv
// N-lane SIMD integer ALU with valid/ready flow control: operand capture, lane compute,
// then masked output register. The whole pipe freezes while a result waits on out_ready.
module vectorial_alu_pipe #(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH*N-1:0] A,
    input  logic [WIDTH*N-1:0] B,
    input  logic [3:0]         sel,
    input  logic [N-1:0]       enable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH*N-1:0] Z,
    output logic [4*N-1:0]     flags,
    output logic [N-1:0]       sticky_ovf,
    input  logic               clr_sticky,
    output logic               illegal_op
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MINU = 4'd2;
    localparam logic [3:0] OP_MAXU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;

    // raw lane result packing: {C, V, Z}
    localparam int LW = WIDTH + 2;

    function automatic logic [LW-1:0] lane_alu(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] rot;
        logic             c;
        logic             v;
        logic             big;
        int               amt;
        ext = '0;
        z   = '0;
        rot = a;
        c   = 1'b0;
        v   = 1'b0;
        amt = int'(b);
        big = (amt >= WIDTH);
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                z   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (z[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                z   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (z[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MINU: z = (a < b) ? a : b;
            OP_MAXU: z = (a < b) ? b : a;
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_XOR:  z = a ^ b;
            // the guard bit next to the lane catches the last bit shifted out
            OP_SHL: begin
                ext = {1'b0, a} << b;
                if (!big) {c, z} = ext;
            end
            OP_SHR: begin
                ext = {a, 1'b0} >> b;
                if (!big) {z, c} = ext;
            end
            OP_SRA: begin
                ext    = $unsigned($signed({a, 1'b0}) >>> b);
                {z, c} = ext;
            end
            OP_ROL: begin
                for (int k = 0; k < WIDTH - 1; k++) begin
                    if (k < amt % WIDTH) rot = {rot[WIDTH-2:0], rot[WIDTH-1]};
                end
                z = rot;
            end
            default: z = '0;
        endcase
        return {c, v, z};
    endfunction

    logic               op_valid_q, op_valid_d;
    logic [WIDTH*N-1:0] a_q, a_d;
    logic [WIDTH*N-1:0] b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    logic [N-1:0]       en_q, en_d;

    logic               res_valid_q, res_valid_d;
    logic [LW*N-1:0]    raw_q, raw_d;
    logic               ill1_q, ill1_d;
    logic [N-1:0]       en1_q, en1_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH*N-1:0] z_q, z_d;
    logic [4*N-1:0]     flags_q, flags_d;
    logic               illegal_q, illegal_d;
    logic [N-1:0]       sticky_q, sticky_d;

    logic               stall;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        op_valid_d  = op_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        en_d        = en_q;
        res_valid_d = res_valid_q;
        raw_d       = raw_q;
        ill1_d      = ill1_q;
        en1_d       = en1_q;
        if (!stall) begin
            op_valid_d = in_valid;
            if (in_valid) begin
                a_d   = A;
                b_d   = B;
                sel_d = sel;
                en_d  = enable;
            end
            res_valid_d = op_valid_q;
            if (op_valid_q) begin
                for (int i = 0; i < N; i++) begin
                    raw_d[i*LW +: LW] = lane_alu(sel_q, a_q[i*WIDTH +: WIDTH], b_q[i*WIDTH +: WIDTH]);
                end
                ill1_d = (sel_q > OP_ROL);
                en1_d  = en_q;
            end
        end
    end

    // disabled lanes keep their last Z; flags are only meaningful for live lanes
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        if (!stall) begin
            out_valid_d = res_valid_q;
            if (res_valid_q) begin
                illegal_d = ill1_q;
                for (int i = 0; i < N; i++) begin
                    flags_d[i*4 +: 4] = 4'b0000;
                    if (en1_q[i]) begin
                        if (ill1_q) begin
                            z_d[i*WIDTH +: WIDTH] = '0;
                        end else begin
                            z_d[i*WIDTH +: WIDTH] = raw_q[i*LW +: WIDTH];
                            flags_d[i*4 +: 4] = {raw_q[i*LW + WIDTH + 1],
                                                 raw_q[i*LW + WIDTH],
                                                 ~|raw_q[i*LW +: WIDTH],
                                                 raw_q[i*LW + WIDTH - 1]};
                        end
                    end
                end
            end
        end
    end

    // set wins over clear when both land on the same edge
    always_comb begin
        sticky_d = sticky_q & {N{~clr_sticky}};
        for (int i = 0; i < N; i++) begin
            if (out_valid_q && out_ready && flags_q[i*4 + 2]) sticky_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            op_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            en_q        <= '0;
            res_valid_q <= 1'b0;
            raw_q       <= '0;
            ill1_q      <= 1'b0;
            en1_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            sticky_q    <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            res_valid_q <= res_valid_d;
            raw_q       <= raw_d;
            ill1_q      <= ill1_d;
            en1_q       <= en1_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign Z          = z_q;
    assign flags      = flags_q;
    assign illegal_op = illegal_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_vectorial_alu_pipe.sv
// Scoreboard bench for vectorial_alu_pipe: stimulus pushes predicted beats, a monitor
// pops and compares on every output transfer and tracks the sticky overflow bits.
module tb_vectorial_alu_pipe;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int WN = W * N;

    logic          clk;
    logic          arst;
    logic          in_valid;
    logic          in_ready;
    logic [WN-1:0] A;
    logic [WN-1:0] B;
    logic [3:0]    sel;
    logic [N-1:0]  enable;
    logic          out_valid;
    logic          out_ready;
    logic [WN-1:0] Z;
    logic [4*N-1:0] flags;
    logic [N-1:0]  sticky_ovf;
    logic          clr_sticky;
    logic          illegal_op;

    vectorial_alu_pipe #(.WIDTH(W), .N(N)) dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .sel        (sel),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Z          (Z),
        .flags      (flags),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WN-1:0]  z;
        logic [4*N-1:0] fl;
        logic           ill;
    } exp_t;

    exp_t         sbq[$];
    int           prev_z[N];
    logic [N-1:0] m_sticky;
    int           checks = 0;
    int           errors = 0;
    bit           rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // lane semantics straight from the opcode rules, plain integer arithmetic
    function automatic void ref_lane(input int op, input int a, input int b,
                                     output int z, output int c, output int v);
        int m = 1 << W;
        int h = m / 2;
        int sa, sb, r;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        z = 0; c = 0; v = 0;
        case (op)
            0: begin r = a + b; z = r % m; c = (r >= m) ? 1 : 0; r = sa + sb; v = (r < -h || r >= h) ? 1 : 0; end
            1: begin r = a - b; z = (r + m) % m; c = (a < b) ? 1 : 0; r = sa - sb; v = (r < -h || r >= h) ? 1 : 0; end
            2: z = (a < b) ? a : b;
            3: z = (a > b) ? a : b;
            4: z = a & b;
            5: z = a | b;
            6: z = a ^ b;
            7: if (b < W) begin z = (a << b) % m; c = (b == 0) ? 0 : (a >> (W - b)) & 1; end
            8: if (b < W) begin z = a >> b; c = (b == 0) ? 0 : (a >> (b - 1)) & 1; end
            9: begin
                if (b >= W) begin
                    z = (sa < 0) ? m - 1 : 0;
                    c = (sa < 0) ? 1 : 0;
                end else begin
                    r = sa >>> b;
                    z = r & (m - 1);
                    c = (b == 0) ? 0 : (a >> (b - 1)) & 1;
                end
            end
            10: begin r = b % W; z = ((a << r) | (a >> (W - r))) % m; end
            default: z = 0;
        endcase
    endfunction

    task automatic predict(input logic [WN-1:0] a, input logic [WN-1:0] b,
                           input logic [3:0] s, input logic [N-1:0] en);
        exp_t e;
        int   z, c, v, la, lb;
        logic [3:0] f;
        e.ill = (s > 4'd10);
        e.z   = '0;
        e.fl  = '0;
        for (int i = 0; i < N; i++) begin
            f = 4'b0000;
            if (en[i]) begin
                if (e.ill) begin
                    prev_z[i] = 0;
                end else begin
                    la = int'(a[i*W +: W]);
                    lb = int'(b[i*W +: W]);
                    ref_lane(int'(s), la, lb, z, c, v);
                    prev_z[i] = z;
                    f = {c[0], v[0], (z == 0), z[W-1]};
                end
            end
            e.z[i*W +: W]  = prev_z[i][W-1:0];
            e.fl[i*4 +: 4] = f;
        end
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [WN-1:0] a, input logic [WN-1:0] b,
                         input logic [3:0] s, input logic [N-1:0] en);
        A = a; B = b; sel = s; enable = en; in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready && arst) begin
                predict(a, b, s, en);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        fail_now("issue_timeout");
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #2;
            if (sbq.size() == 0) return;
        end
        fail_now("drain_timeout");
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin : monitor
        exp_t         e;
        logic [N-1:0] set;
        forever begin
            @(negedge clk);
            if (!arst) begin
                chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
                chk("rst_sticky", {30'b0, sticky_ovf}, 32'd0);
                m_sticky = '0;
            end else begin
                chk("sticky_ovf", {30'b0, sticky_ovf}, {30'b0, m_sticky});
                set = '0;
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = sbq.pop_front();
                        chk("beat_Z", {24'b0, Z}, {24'b0, e.z});
                        chk("beat_flags", {24'b0, flags}, {24'b0, e.fl});
                        chk("beat_illegal", {31'b0, illegal_op}, {31'b0, e.ill});
                        for (int i = 0; i < N; i++) set[i] = e.fl[i*4 + 2];
                    end
                end
                m_sticky = (m_sticky & ~{N{clr_sticky}}) | set;
            end
        end
    end

    initial begin : stim
        logic [WN-1:0] ra, rb;
        arst = 1'b0; in_valid = 1'b1; A = 8'hFF; B = 8'h11; sel = 4'd0; enable = 2'b11;
        out_ready = 1'b1; clr_sticky = 1'b0;
        for (int i = 0; i < N; i++) prev_z[i] = 0;
        m_sticky = '0;

        // reset with in_valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_Z", {24'b0, Z}, 32'd0);
        chk("reset_flags", {24'b0, flags}, 32'd0);
        chk("reset_illegal", {31'b0, illegal_op}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        arst = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // latency: out_valid rises after the second edge following acceptance
        @(posedge clk); #1;
        A = 8'h21; B = 8'h12; sel = 4'd0; enable = 2'b11; in_valid = 1'b1;
        @(negedge clk);
        chk("latency_accept", {31'b0, in_ready}, 32'd1);
        predict(A, B, sel, enable);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_k", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("latency_k1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("latency_k2", {31'b0, out_valid}, 32'd1);
        drain();

        // ADD with lane0 signed overflow and lane1 carry
        issue(8'hF7, 8'h11, 4'd0, 2'b11);
        drain();
        chk("add_sticky", {30'b0, sticky_ovf}, 32'd1);
        @(posedge clk); #1; clr_sticky = 1'b1;
        @(posedge clk); #1; clr_sticky = 1'b0;
        chk("clr_sticky", {30'b0, sticky_ovf}, 32'd0);

        // shifts and rotate around the WIDTH boundary
        issue(8'h8F, 8'h41, 4'd9, 2'b11);
        issue(8'h8F, 8'h41, 4'd8, 2'b11);
        issue(8'h8F, 8'h41, 4'd7, 2'b11);
        issue(8'h9B, 8'h53, 4'd10, 2'b11);
        issue(8'h4C, 8'h03, 4'd9, 2'b11);
        drain();

        // backpressure: pipe fills, in_ready drops, Z holds
        out_ready = 1'b0;
        issue(8'h11, 8'h11, 4'd0, 2'b11);
        issue(8'h33, 8'h11, 4'd1, 2'b11);
        issue(8'h55, 8'h33, 4'd6, 2'b11);
        A = 8'h3C; B = 8'hFF; sel = 4'd4; enable = 2'b11; in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_Z_hold", {24'b0, Z}, 32'h22);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(8'h3C, 8'hFF, 4'd4, 2'b11);
        drain();

        // lane mask then illegal opcode, then a legal beat
        issue(8'hF0, 8'hFF, 4'd4, 2'b10);
        issue(8'h12, 8'h34, 4'd15, 2'b10);
        issue(8'h12, 8'h34, 4'd2, 2'b11);
        drain();
        chk("illegal_cleared", {31'b0, illegal_op}, 32'd0);

        // random traffic with random backpressure and sticky clears
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ra = WN'($urandom);
            rb = WN'($urandom);
            clr_sticky = ($urandom_range(0, 7) == 0);
            issue(ra, rb, 4'($urandom_range(0, 15)), N'($urandom_range(0, (1 << N) - 1)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        clr_sticky = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        // reset with two beats in flight
        issue(8'h77, 8'h11, 4'd0, 2'b11);
        issue(8'h66, 8'h22, 4'd1, 2'b11);
        @(posedge clk); #1;
        chk("inflight_out_valid", {31'b0, out_valid}, 32'd1);
        arst = 1'b0;
        sbq.delete();
        for (int i = 0; i < N; i++) prev_z[i] = 0;
        in_valid = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_Z", {24'b0, Z}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        arst = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #2;
            chk("post_rst_no_beat", {31'b0, out_valid}, 32'd0);
        end
        issue(8'h12, 8'h21, 4'd5, 2'b11);
        drain();

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
